// File: rtl/residual_pkg.sv
// Shared helpers for the residual merge stage: frame sizing and signed
// saturation on a wide intermediate.
package residual_pkg;

  // Widest intermediate handled by saturate(); covers a 2*64-bit product.
  localparam int SAT_W = 128;

  function automatic int total_pix(input int img, input int ch);
    return img * img * ch;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_max(input int width);
    return {SAT_W{1'b1}} >> (SAT_W - width + 1);
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_min(input int width);
    return ~sat_max(width);
  endfunction

  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] x,
                                                       input int width);
    logic signed [SAT_W-1:0] hi, lo;
    hi = sat_max(width);
    lo = sat_min(width);
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/sync_fifo_sc.sv
// Single-clock FIFO with fall-through read data; a push while full is only
// taken when a pop frees the head slot in the same cycle.
module sync_fifo_sc #(
  parameter int W     = 32,
  parameter int DEPTH = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_wr, w_rd;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/residual_scale_add.sv
// Residual merge: out = shortcut + scale*branch (Q fixed point), optional
// ReLU, saturating, with a shortcut FIFO and per-frame scale/relu latch.
module residual_scale_add
  import residual_pkg::*;
#(
  parameter int IMG_SIZE   = 8,
  parameter int CHANNELS   = 2080,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in_1,
  input  logic [DATA_WIDTH-1:0]         pxl_in_1,
  input  logic                          valid_in_2,
  input  logic [DATA_WIDTH-1:0]         pxl_in_2,
  input  logic [DATA_WIDTH-1:0]         scale,
  input  logic                          relu_en,
  output logic [DATA_WIDTH-1:0]         pxl_out,
  output logic                          valid_out,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_overflow,
  output logic                          err_underflow
);
  localparam int DW     = DATA_WIDTH;
  localparam int TOTAL  = total_pix(IMG_SIZE, CHANNELS);
  localparam int CW     = $clog2(TOTAL + 1);
  localparam int STAGES = 2;

  logic [DW-1:0] w_fifo_dout;
  logic          w_full, w_empty;
  logic          w_bypass, w_accept, w_fifo_push, w_fifo_pop;
  logic          w_first, w_last, w_relu_cur;
  logic [DW-1:0] w_scale_cur, w_shortcut;

  logic signed [2*DW-1:0] w_prod, w_prod_sh;
  logic signed [DW-1:0]   w_prod_sat;
  logic signed [DW:0]     w_sum;
  logic signed [DW-1:0]   w_sum_sat;

  logic [CW-1:0]      r_in_cnt;
  logic [DW-1:0]      r_scale_l;
  logic               r_relu_l;
  logic [STAGES:1]    r_vld_pipe;
  logic [DW-1:0]      r_s1_sc, r_s1_prod;
  logic               r_s1_relu, r_s1_last;

  assign w_fifo_pop  = valid_in_2 && !w_empty;
  assign w_bypass    = valid_in_2 && w_empty && valid_in_1;
  assign w_accept    = w_fifo_pop || w_bypass;
  assign w_fifo_push = valid_in_1 && !w_bypass;
  assign w_shortcut  = w_bypass ? pxl_in_1 : w_fifo_dout;

  sync_fifo_sc #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_fifo_push),
    .i_data  (pxl_in_1),
    .i_pop   (w_fifo_pop),
    .o_data  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // First pixel of a frame uses the live scale/relu; the rest use the latch.
  assign w_first     = (r_in_cnt == '0);
  assign w_last      = (r_in_cnt == CW'(TOTAL - 1));
  assign w_scale_cur = w_first ? scale   : r_scale_l;
  assign w_relu_cur  = w_first ? relu_en : r_relu_l;

  always_comb begin
    w_prod     = $signed(pxl_in_2) * $signed(w_scale_cur);
    w_prod_sh  = w_prod >>> FRAC_BITS;
    w_prod_sat = DW'(saturate(SAT_W'(w_prod_sh), DW));
    w_sum      = $signed({r_s1_sc[DW-1], r_s1_sc}) + $signed({r_s1_prod[DW-1], r_s1_prod});
    w_sum_sat  = DW'(saturate(SAT_W'(w_sum), DW));
    if (r_s1_relu && w_sum_sat[DW-1]) w_sum_sat = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_cnt      <= '0;
      r_scale_l     <= '0;
      r_relu_l      <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (valid_in_1 && w_full && !w_fifo_pop) err_overflow <= 1'b1;
      if (valid_in_2 && w_empty && !valid_in_1) err_underflow <= 1'b1;
      if (w_accept) begin
        r_in_cnt <= w_last ? '0 : r_in_cnt + 1'b1;
        if (w_first) begin
          r_scale_l <= scale;
          r_relu_l  <= relu_en;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_pipe <= '0;
      r_s1_sc    <= '0;
      r_s1_prod  <= '0;
      r_s1_relu  <= 1'b0;
      r_s1_last  <= 1'b0;
      pxl_out    <= '0;
      frame_done <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_accept};
      if (w_accept) begin
        r_s1_sc   <= w_shortcut;
        r_s1_prod <= w_prod_sat;
        r_s1_relu <= w_relu_cur;
        r_s1_last <= w_last;
      end
      if (r_vld_pipe[1]) pxl_out <= w_sum_sat;
      frame_done <= r_vld_pipe[1] && r_s1_last;
    end
  end

  assign valid_out = r_vld_pipe[STAGES];

endmodule

// File: tb/tb_residual_scale_add.sv
// Directed bench for residual_scale_add with a 2x2x2 frame and a 4-deep FIFO.
module tb_residual_scale_add;
  localparam int DW = 32;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          valid_in_1 = 1'b0, valid_in_2 = 1'b0, relu_en = 1'b0;
  logic [DW-1:0] pxl_in_1 = '0, pxl_in_2 = '0, scale = '0;
  logic [DW-1:0] pxl_out;
  logic          valid_out, frame_done, err_overflow, err_underflow;
  logic [LW-1:0] fifo_level;

  int errors = 0;
  int checks = 0;

  residual_scale_add #(
    .IMG_SIZE(2), .CHANNELS(2), .DATA_WIDTH(DW), .FRAC_BITS(16), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .valid_in_1(valid_in_1), .pxl_in_1(pxl_in_1),
    .valid_in_2(valid_in_2), .pxl_in_2(pxl_in_2),
    .scale(scale), .relu_en(relu_en),
    .pxl_out(pxl_out), .valid_out(valid_out), .frame_done(frame_done),
    .fifo_level(fifo_level),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    valid_in_1 = 1'b0; valid_in_2 = 1'b0; relu_en = 1'b0;
    pxl_in_1 = '0; pxl_in_2 = '0; scale = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", valid_out); end
    checks++; if (pxl_out !== 32'h0) begin errors++; $display("FAIL rst_pxl got %0h exp 0", pxl_out); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %0h exp 0", frame_done); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
    checks++; if ({err_overflow, err_underflow} !== 2'b00) begin errors++; $display("FAIL rst_errs got %b exp 00", {err_overflow, err_underflow}); end
  endtask

  task automatic test_basic();
    apply_reset();
    scale = 32'h0000_4000;
    valid_in_1 = 1'b1; pxl_in_1 = 32'h0001_0000;
    tick();
    valid_in_1 = 1'b0;
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL basic_level1 got %0d exp 1", fifo_level); end
    valid_in_2 = 1'b1; pxl_in_2 = 32'h0002_0000;
    tick();
    valid_in_2 = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0h exp 0", valid_out); end
    tick();
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL basic_valid got %0h exp 1", valid_out); end
    checks++; if (pxl_out !== 32'h0001_8000) begin errors++; $display("FAIL basic_pxl got %h exp 00018000", pxl_out); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL basic_level0 got %0d exp 0", fifo_level); end
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %0h exp 0", valid_out); end
    checks++; if (pxl_out !== 32'h0001_8000) begin errors++; $display("FAIL basic_hold got %h exp 00018000", pxl_out); end
  endtask

  task automatic test_sat_relu();
    apply_reset();
    scale = 32'h0001_0000;
    valid_in_1 = 1'b1; pxl_in_1 = 32'h7FFF_0000;
    valid_in_2 = 1'b1; pxl_in_2 = 32'h7FFF_0000;
    tick();
    // rest of frame 0 with zero data so the next pixel opens a new frame
    pxl_in_1 = '0; pxl_in_2 = '0;
    tick();
    checks++; if (pxl_out !== 32'h7FFF_FFFF || valid_out !== 1'b1) begin errors++; $display("FAIL sat_pos got %h v=%0h exp 7fffffff v=1", pxl_out, valid_out); end
    for (int i = 0; i < 6; i++) tick();
    relu_en = 1'b1;
    pxl_in_1 = 32'hFFFF_0000; pxl_in_2 = 32'h0;
    tick();
    valid_in_1 = 1'b0; valid_in_2 = 1'b0;
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL sat_frame0_done got %0h exp 1", frame_done); end
    tick();
    checks++; if (valid_out !== 1'b1 || pxl_out !== 32'h0) begin errors++; $display("FAIL relu_clamp got %h v=%0h exp 0 v=1", pxl_out, valid_out); end
  endtask

  task automatic test_fifo_boundary();
    logic [DW-1:0] exp_q [5];
    exp_q[0] = 32'h0001_0000; exp_q[1] = 32'h0002_0000; exp_q[2] = 32'h0003_0000;
    exp_q[3] = 32'h0004_0000; exp_q[4] = 32'h0006_0000;
    apply_reset();
    scale = 32'h0001_0000;
    for (int i = 1; i <= 5; i++) begin
      valid_in_1 = 1'b1; pxl_in_1 = DW'(i) << 16;
      tick();
    end
    valid_in_1 = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", fifo_level); end
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0h exp 1", err_overflow); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL ovf_no_udf got %0h exp 0", err_underflow); end
    valid_in_1 = 1'b1; pxl_in_1 = 32'h0006_0000;
    valid_in_2 = 1'b1; pxl_in_2 = 32'h0;
    tick();
    valid_in_1 = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_pushpop_level got %0d exp 4", fifo_level); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (valid_out !== 1'b1 || pxl_out !== exp_q[i]) begin errors++; $display("FAIL drain_%0d got %h v=%0h exp %h", i, pxl_out, valid_out, exp_q[i]); end
    end
    valid_in_2 = 1'b0;
    tick();
    checks++; if (valid_out !== 1'b1 || pxl_out !== exp_q[4]) begin errors++; $display("FAIL drain_4 got %h v=%0h exp %h", pxl_out, valid_out, exp_q[4]); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL drain_level got %0d exp 0", fifo_level); end
  endtask

  task automatic test_underflow_bypass();
    apply_reset();
    scale = 32'h0001_0000;
    valid_in_2 = 1'b1; pxl_in_2 = 32'h0005_0000;
    tick();
    valid_in_2 = 1'b0;
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL udf_no_valid got %0h exp 0", valid_out); end
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL udf_flag got %0h exp 1", err_underflow); end
    valid_in_1 = 1'b1; pxl_in_1 = 32'h0001_0000;
    valid_in_2 = 1'b1; pxl_in_2 = 32'h0;
    tick();
    valid_in_1 = 1'b0; valid_in_2 = 1'b0;
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL bypass_level got %0d exp 0", fifo_level); end
    tick();
    checks++; if (valid_out !== 1'b1 || pxl_out !== 32'h0001_0000) begin errors++; $display("FAIL bypass_pxl got %h v=%0h exp 00010000 v=1", pxl_out, valid_out); end
    checks++; if (err_underflow !== 1'b1 || err_overflow !== 1'b0) begin errors++; $display("FAIL udf_sticky got u=%0h o=%0h exp u=1 o=0", err_underflow, err_overflow); end
  endtask

  task automatic test_frame();
    logic [DW-1:0] exp_v;
    apply_reset();
    for (int c = 0; c <= 10; c++) begin
      if (c < 9) begin
        valid_in_1 = 1'b1; pxl_in_1 = 32'h0;
        valid_in_2 = 1'b1; pxl_in_2 = 32'h0001_0000;
        scale = (c >= 3) ? 32'h0002_0000 : 32'h0001_0000;
      end else begin
        valid_in_1 = 1'b0; valid_in_2 = 1'b0;
      end
      tick();
      if (c >= 1 && c <= 9) begin
        exp_v = (c - 1 == 8) ? 32'h0002_0000 : 32'h0001_0000;
        checks++; if (valid_out !== 1'b1 || pxl_out !== exp_v) begin errors++; $display("FAIL frame_pix%0d got %h v=%0h exp %h", c - 1, pxl_out, valid_out, exp_v); end
        checks++; if (frame_done !== (c - 1 == 7)) begin errors++; $display("FAIL frame_done_pix%0d got %0h exp %0h", c - 1, frame_done, (c - 1 == 7)); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    scale = 32'h0001_0000;
    for (int i = 1; i <= 4; i++) begin
      valid_in_1 = 1'b1; pxl_in_1 = DW'(i) << 16;
      tick();
    end
    valid_in_1 = 1'b0;
    valid_in_2 = 1'b1; pxl_in_2 = 32'h0;
    tick();
    valid_in_1 = 1'b1; pxl_in_1 = 32'h0005_0000;
    tick();
    checks++; if (fifo_level !== 3'd3 || valid_out !== 1'b1) begin errors++; $display("FAIL mid_prefill got lvl=%0d v=%0h exp lvl=3 v=1", fifo_level, valid_out); end
    #2 reset = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0 || pxl_out !== 32'h0 || fifo_level !== 3'd0) begin errors++; $display("FAIL mid_async got v=%0h p=%h lvl=%0d exp 0", valid_out, pxl_out, fifo_level); end
    valid_in_1 = 1'b0; valid_in_2 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++; if (valid_out !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL mid_after got v=%0h lvl=%0d exp v=0 lvl=0", valid_out, fifo_level); end
    valid_in_1 = 1'b1; pxl_in_1 = 32'h0007_0000;
    tick();
    valid_in_1 = 1'b0;
    valid_in_2 = 1'b1; pxl_in_2 = 32'h0001_0000;
    tick();
    valid_in_2 = 1'b0;
    tick();
    checks++; if (valid_out !== 1'b1 || pxl_out !== 32'h0008_0000) begin errors++; $display("FAIL mid_fresh got %h v=%0h exp 00080000 v=1", pxl_out, valid_out); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_fresh_level got %0d exp 0", fifo_level); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sat_relu();
    test_fifo_boundary();
    test_underflow_bypass();
    test_frame();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
